tpuv2_ctrl: RTL and testbench

//  Memory-mapped sequencer for a DIM x DIM systolic matrix-multiply unit; successor to the v1 TPU top.

---
 rtl/tpuv2_ctrl_if.sv | 18 +
 rtl/tpuv2_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_tpuv2_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpuv2_ctrl_if.sv
// Host access bus of tpuv2_ctrl: one request per cycle, read data returned one cycle later.
interface tpuv2_ctrl_if #(
  parameter int ADDRW = 16,
  parameter int DATAW = 64
);
  // Handshake: req is a valid strobe without back-pressure, so every request is taken in the
  // cycle it is presented; each read (r_w=0) answers with exactly one rd_valid pulse, carrying
  // dataOut, in the following cycle. Writes produce no response on this bus.
  logic             req;
  logic             r_w;
  logic [ADDRW-1:0] addr;
  logic [DATAW-1:0] dataIn;
  logic [DATAW-1:0] dataOut;
  logic             rd_valid;

  modport master (output req, r_w, addr, dataIn, input dataOut, rd_valid);
  modport slave  (input req, r_w, addr, dataIn, output dataOut, rd_valid);
endinterface

// File: rtl/tpuv2_ctrl.sv
// Memory-mapped sequencer for a DIM x DIM systolic matrix-multiply unit (memA/memB/array control).
// Build macro TPU_PERF_CNT_EN adds a RUN-cycle / rejected-access counter CSR at BASE_CSR+2*DATAW/8.
module tpuv2_ctrl #(
  parameter int               BITS_AB  = 8,
  parameter int               BITS_C   = 16,
  parameter int               DIM      = 8,
  parameter int               ADDRW    = 16,
  parameter int               DATAW    = 64,
  parameter logic [ADDRW-1:0] BASE_A   = 'h100,
  parameter logic [ADDRW-1:0] BASE_B   = 'h200,
  parameter logic [ADDRW-1:0] BASE_C   = 'h300,
  parameter logic [ADDRW-1:0] BASE_CSR = 'h400
) (
  input  logic                    clk,
  input  logic                    rst,
  tpuv2_ctrl_if.slave             host,
  output logic                    a_en,
  output logic                    a_wr,
  output logic [$clog2(DIM)-1:0]  a_row,
  output logic [DIM*BITS_AB-1:0]  a_din,
  output logic                    b_en,
  output logic [DIM*BITS_AB-1:0]  b_din,
  output logic                    sa_en,
  output logic                    c_wr,
  output logic [$clog2(DIM)-1:0]  c_row,
  output logic [DIM*BITS_C-1:0]   c_din,
  input  logic [DIM*BITS_C-1:0]   c_dout,
  output logic                    busy
);
  localparam int RW     = $clog2(DIM);
  localparam int STRIDE = DATAW / 8;
  localparam int CW     = (DIM * BITS_C) / DATAW;
  localparam int SW     = (CW > 1) ? $clog2(CW) : 1;
  localparam int NSTEPS = 3 * DIM - 2;
  localparam int CNTW   = $clog2(NSTEPS + 1);

  localparam logic [ADDRW-1:0] STRIDE_L = ADDRW'(STRIDE);
  localparam logic [ADDRW-1:0] AB_SPAN  = ADDRW'(DIM * STRIDE);
  localparam logic [ADDRW-1:0] C_SPAN   = ADDRW'(DIM * CW * STRIDE);
  localparam logic [ADDRW-1:0] CSR_SPAN = ADDRW'(3 * STRIDE);
  localparam logic [ADDRW-1:0] CW_L     = ADDRW'(CW);

  typedef enum logic {IDLE, RUN} state_t;

  // Address decode; anything past the last row of a window falls out of every hit.
  logic [ADDRW-1:0] off_a, off_b, off_c, off_csr, word_c;
  logic             hit_a, hit_b, hit_c, hit_csr;
  logic [RW-1:0]    row_a, row_c;
  logic [SW-1:0]    sub_c;
  logic [1:0]       csr_idx;

  always_comb begin
    off_a   = host.addr - BASE_A;
    off_b   = host.addr - BASE_B;
    off_c   = host.addr - BASE_C;
    off_csr = host.addr - BASE_CSR;
    hit_a   = (host.addr >= BASE_A)   && (off_a   < AB_SPAN);
    hit_b   = (host.addr >= BASE_B)   && (off_b   < AB_SPAN);
    hit_c   = (host.addr >= BASE_C)   && (off_c   < C_SPAN);
    hit_csr = (host.addr >= BASE_CSR) && (off_csr < CSR_SPAN);
    word_c  = off_c / STRIDE_L;
    row_a   = RW'(off_a / STRIDE_L);
    row_c   = RW'(word_c / CW_L);
    sub_c   = SW'(word_c % CW_L);
    csr_idx = 2'(off_csr / STRIDE_L);
  end

  state_t                state_q, state_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic                  done_q, done_d, err_q, err_d;
  logic                  a_wr_q, a_wr_d, b_wr_q, b_wr_d, c_wr_q, c_wr_d;
  logic [RW-1:0]         a_row_q, a_row_d, c_row_q, c_row_d;
  logic [DIM*BITS_AB-1:0] a_din_q, a_din_d, b_din_q, b_din_d;
  logic [DIM*BITS_C-1:0] c_din_q, c_din_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATAW-1:0]      dout_q, dout_d;
`ifdef TPU_PERF_CNT_EN
  logic [31:0]           perf_cyc_q, perf_cyc_d;
  logic [15:0]           perf_rej_q, perf_rej_d;
`endif

  logic             idle, wr, rd, c_access, cmd_hit, reject;
  logic [DATAW-1:0] status_word, perf_word;

  always_comb begin
    idle     = (state_q == IDLE);
    wr       = host.req && host.r_w;
    rd       = host.req && !host.r_w;
    c_access = !rst && host.req && hit_c && idle;
    // C row is steered combinationally so c_dout is valid for the merge/read in the request cycle.
    c_row    = c_access ? row_c : c_row_q;
    cmd_hit  = hit_csr && (csr_idx == 2'd0);
    reject   = !idle && ((wr && (hit_a || hit_b || hit_c || cmd_hit)) || (rd && hit_c));
    status_word = DATAW'({err_q, done_q, !idle});
`ifdef TPU_PERF_CNT_EN
    perf_word = DATAW'(perf_cyc_q) | ((DATAW >= 64) ? (DATAW'(perf_rej_q) << 48) : '0);
`else
    perf_word = '0;
`endif

    state_d    = state_q;
    count_d    = count_q;
    done_d     = done_q;
    err_d      = err_q || reject;
    a_wr_d     = 1'b0;
    a_row_d    = '0;
    a_din_d    = '0;
    b_wr_d     = 1'b0;
    b_din_d    = '0;
    c_wr_d     = 1'b0;
    c_row_d    = c_row;
    c_din_d    = '0;
    rd_valid_d = rd;
    dout_d     = '0;

    if (!idle) begin
      if (count_q == CNTW'(NSTEPS)) begin
        state_d = IDLE;
        count_d = '0;
        done_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    if (wr && idle) begin
      if (hit_a) begin
        a_wr_d  = 1'b1;
        a_row_d = row_a;
        a_din_d = host.dataIn;
      end
      if (hit_b) begin
        b_wr_d  = 1'b1;
        b_din_d = host.dataIn;
      end
      if (hit_c) begin
        c_wr_d  = 1'b1;
        c_din_d = c_dout;
        c_din_d[sub_c*DATAW +: DATAW] = host.dataIn;
      end
      if (cmd_hit) begin
        state_d = RUN;
        count_d = CNTW'(1);
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
    end

    if (rd) begin
      if (hit_c && idle)                      dout_d = c_dout[sub_c*DATAW +: DATAW];
      else if (hit_csr && csr_idx == 2'd1)    dout_d = status_word;
      else if (hit_csr && csr_idx == 2'd2)    dout_d = perf_word;
    end

`ifdef TPU_PERF_CNT_EN
    perf_cyc_d = perf_cyc_q + 32'(!idle);
    perf_rej_d = perf_rej_q + 16'(reject);
    if (wr && idle && cmd_hit) begin
      perf_cyc_d = '0;
      perf_rej_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      a_wr_q     <= 1'b0;
      a_row_q    <= '0;
      a_din_q    <= '0;
      b_wr_q     <= 1'b0;
      b_din_q    <= '0;
      c_wr_q     <= 1'b0;
      c_row_q    <= '0;
      c_din_q    <= '0;
      rd_valid_q <= 1'b0;
      dout_q     <= '0;
`ifdef TPU_PERF_CNT_EN
      perf_cyc_q <= '0;
      perf_rej_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      done_q     <= done_d;
      err_q      <= err_d;
      a_wr_q     <= a_wr_d;
      a_row_q    <= a_row_d;
      a_din_q    <= a_din_d;
      b_wr_q     <= b_wr_d;
      b_din_q    <= b_din_d;
      c_wr_q     <= c_wr_d;
      c_row_q    <= c_row_d;
      c_din_q    <= c_din_d;
      rd_valid_q <= rd_valid_d;
      dout_q     <= dout_d;
`ifdef TPU_PERF_CNT_EN
      perf_cyc_q <= perf_cyc_d;
      perf_rej_q <= perf_rej_d;
`endif
    end
  end

  // The enables are the RUN state itself, so they span exactly NSTEPS cycles.
  assign busy          = (state_q == RUN);
  assign a_en          = busy;
  assign sa_en         = busy;
  assign b_en          = busy || b_wr_q;
  assign a_wr          = a_wr_q;
  assign a_row         = a_row_q;
  assign a_din         = a_din_q;
  assign b_din         = b_din_q;
  assign c_wr          = c_wr_q;
  assign c_din         = c_din_q;
  assign host.dataOut  = dout_q;
  assign host.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_tpuv2_ctrl.sv
// Randomised scoreboard bench for tpuv2_ctrl; expectations come from a transaction-level model
// of the register map, C row storage and compute timing.
`timescale 1ns/1ps
module tb_tpuv2_ctrl;
  localparam int DIM = 8, DATAW = 64, ADDRW = 16, RW = 3, CW = 2, CWID = DIM * 16;
  localparam int NSTEPS = 3 * DIM - 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tpuv2_ctrl_if #(.ADDRW(ADDRW), .DATAW(DATAW)) host ();
  logic            a_en, a_wr, b_en, sa_en, c_wr, busy;
  logic [RW-1:0]   a_row, c_row;
  logic [63:0]     a_din, b_din;
  logic [CWID-1:0] c_din, c_dout;

  tpuv2_ctrl dut (
    .clk(clk), .rst(rst), .host(host),
    .a_en(a_en), .a_wr(a_wr), .a_row(a_row), .a_din(a_din),
    .b_en(b_en), .b_din(b_din), .sa_en(sa_en),
    .c_wr(c_wr), .c_row(c_row), .c_din(c_din), .c_dout(c_dout),
    .busy(busy)
  );

  // Stand-in for the array's C storage, written by the DUT's merged rows.
  logic [CWID-1:0] c_arr  [DIM];
  logic [CWID-1:0] init_c [DIM];
  assign c_dout = c_arr[c_row];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++) c_arr[i] <= init_c[i];
    end else if (c_wr) begin
      c_arr[c_row] <= c_din;
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [DATAW-1:0]    exp_q   [$];
  logic [RW+DATAW-1:0] exp_a_q [$];
  logic [DATAW-1:0]    exp_b_q [$];
  logic [RW+CWID-1:0]  exp_c_q [$];
  int                  exp_run_q [$];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected pulse expected none", name);
  endtask

  // ---------------- reference model ----------------
  logic [CWID-1:0] m_c [DIM];
  bit m_done, m_err, m_pending;
  int m_run_until, m_cmd_cyc, m_rej;

  task automatic model_reset();
    m_done = 0; m_err = 0; m_pending = 0;
    m_run_until = -1; m_cmd_cyc = -1; m_rej = 0;
    exp_q.delete(); exp_a_q.delete(); exp_b_q.delete(); exp_c_q.delete(); exp_run_q.delete();
  endtask

  task automatic model_reject();
    m_err = 1;
    m_rej++;
  endtask

  // ---------------- driver ----------------
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input bit w, input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d);
    int k, ai, word, row, sub, ncyc;
    bit bsy;
    logic [DATAW-1:0] rv;
    k    = cyc + 1;
    ai   = int'(a);
    bsy  = (k <= m_run_until);
    if (!bsy && m_pending) begin
      m_done = 1; m_pending = 0;
    end
    word = (ai - 'h300) / 8;
    row  = word / CW;
    sub  = word % CW;
    rv   = '0;
    if (w) begin
      if (ai >= 'h100 && ai < 'h100 + DIM * 8) begin
        if (bsy) model_reject(); else exp_a_q.push_back({3'((ai - 'h100) / 8), d});
      end else if (ai >= 'h200 && ai < 'h200 + DIM * 8) begin
        if (bsy) model_reject(); else exp_b_q.push_back(d);
      end else if (ai >= 'h300 && ai < 'h300 + DIM * CW * 8) begin
        if (bsy) model_reject();
        else begin
          m_c[row][sub*DATAW +: DATAW] = d;
          exp_c_q.push_back({3'(row), m_c[row]});
        end
      end else if (ai >= 'h400 && ai < 'h408) begin
        if (bsy) model_reject();
        else begin
          m_run_until = k + NSTEPS; m_cmd_cyc = k;
          m_done = 0; m_err = 0; m_rej = 0; m_pending = 1;
          exp_run_q.push_back(NSTEPS);
        end
      end
    end else begin
      if (ai >= 'h300 && ai < 'h300 + DIM * CW * 8) begin
        if (bsy) model_reject(); else rv = m_c[row][sub*DATAW +: DATAW];
      end else if (ai >= 'h408 && ai < 'h410) begin
        rv = DATAW'({m_err, m_done, bsy});
      end else if (ai >= 'h410 && ai < 'h418) begin
`ifdef TPU_PERF_CNT_EN
        ncyc = (m_cmd_cyc < 0) ? 0 : (k - m_cmd_cyc - 1);
        if (ncyc > NSTEPS) ncyc = NSTEPS;
        rv = DATAW'(ncyc) | (DATAW'(m_rej) << 48);
`else
        ncyc = 0;
        rv = '0;
`endif
      end
      exp_q.push_back(rv);
    end
    host.req = 1'b1; host.r_w = w; host.addr = a; host.dataIn = d;
    @(posedge clk);
    #1;
    host.req = 1'b0;
    if (w && ai >= 'h300 && ai < 'h380) wait_cycles(1);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && exp_a_q.size() == 0 && exp_b_q.size() == 0 &&
          exp_c_q.size() == 0 && exp_run_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
      wait_cycles(1);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0",
               exp_q.size() + exp_a_q.size() + exp_b_q.size() + exp_c_q.size() + exp_run_q.size());
    end
  endtask

  // ---------------- monitor ----------------
  int run_len = 0;
  bit prev_sa = 0;
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
      prev_sa = 0;
    end else begin
      if (host.rd_valid) begin
        if (exp_q.size() == 0) unexpected("rd_valid");
        else check("read_data", 160'(host.dataOut), 160'(exp_q.pop_front()));
      end
      if (a_wr) begin
        if (exp_a_q.size() == 0) unexpected("a_wr");
        else check("a_write", 160'({a_row, a_din}), 160'(exp_a_q.pop_front()));
      end
      if (b_en && !busy) begin
        if (exp_b_q.size() == 0) unexpected("b_en");
        else check("b_write", 160'(b_din), 160'(exp_b_q.pop_front()));
      end
      if (c_wr) begin
        if (exp_c_q.size() == 0) unexpected("c_wr");
        else check("c_write", 160'({c_row, c_din}), 160'(exp_c_q.pop_front()));
      end
      if (sa_en) begin
        run_len++;
        check("run_enables", 160'({a_en, b_en, busy, b_din}), 160'({3'b111, 64'h0}));
      end
      if (!sa_en && prev_sa) begin
        if (exp_run_q.size() == 0) unexpected("run_end");
        else check("run_length", 160'(run_len), 160'(exp_run_q.pop_front()));
        run_len = 0;
      end
      prev_sa = sa_en;
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [ADDRW-1:0] a;
    logic [DATAW-1:0] d;
    host.req = 0; host.r_w = 0; host.addr = '0; host.dataIn = '0;
    for (int i = 0; i < DIM; i++) m_c[i] = {$urandom, $urandom, $urandom, $urandom};
    m_c[1] = '0;
    init_c = m_c;
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 160'({a_en, a_wr, a_row, b_en, sa_en, c_wr, c_row, busy, host.rd_valid}), 160'(0));
    check("reset_a_b_din", 160'({a_din, b_din}), 160'(0));
    check("reset_c_din", 160'(c_din), 160'(0));
    check("reset_dout", 160'(host.dataOut), 160'(0));
    @(posedge clk);
    #1;
    rst = 0;

    // Directed cases
    issue(1, 'h108, 64'h0807060504030201);
    issue(1, 'h318, 64'hDEADBEEF_CAFEF00D);
    issue(0, 'h318, '0);
    issue(0, 'h310, '0);
    issue(1, 'h200, 64'h1122334455667788);
    issue(0, 'h140, '0);
    issue(1, 'h400, '0);
    drain();
    issue(0, 'h408, '0);
    issue(0, 'h410, '0);
    issue(1, 'h400, '0);
    wait_cycles(3);
    issue(1, 'h208, 64'hFFFF);
    drain();
    issue(0, 'h408, '0);
    issue(0, 'h410, '0);
    issue(1, 'h400, '0);
    issue(0, 'h300, '0);
    issue(0, 'h408, '0);
    drain();

    // Reset while computing (count=5)
    issue(1, 'h400, '0);
    wait_cycles(4);
    init_c = m_c;
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_busy_sa_en", 160'({busy, sa_en}), 160'(0));
    @(posedge clk);
    #1;
    rst = 0;
    issue(0, 'h408, '0);
    issue(0, 'h410, '0);
    drain();

    // Randomised traffic
    for (int n = 0; n < 250; n++) begin
      d = {$urandom, $urandom};
      case ($urandom_range(0, 11))
        0:       issue(1, 16'('h100 + 8 * $urandom_range(0, DIM - 1)), d);
        1:       issue(1, 16'('h200 + 8 * $urandom_range(0, DIM - 1)), d);
        2, 3:    issue(1, 16'('h300 + 8 * $urandom_range(0, DIM * CW - 1)), d);
        4, 5:    issue(0, 16'('h300 + 8 * $urandom_range(0, DIM * CW - 1)), d);
        6:       issue(0, 'h408, d);
        7:       issue(0, 'h410, d);
        8:       if ($urandom_range(0, 2) == 0) issue(1, 'h400, d); else issue(0, 'h408, d);
        9: begin
          a = ($urandom_range(0, 1) == 0) ? 16'('h140 + 8 * $urandom_range(0, 7))
                                          : 16'('h380 + 8 * $urandom_range(0, 15));
          issue(1'($urandom_range(0, 1)), a, d);
        end
        10: begin
          a = ($urandom_range(0, 1) == 0) ? 16'(8 * $urandom_range(0, 31)) : 16'('h408);
          issue(1'($urandom_range(0, 1)), a, d);
        end
        default: issue(0, 16'('h100 + 8 * $urandom_range(0, 2 * DIM - 1)), d);
      endcase
      wait_cycles($urandom_range(0, 2));
    end
    drain();
    issue(0, 'h408, '0);
    issue(0, 'h410, '0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
